// File: rtl/alsu_sequencer.sv
// alsu_sequencer
// Round-robin sequencer between two command ports and a single ALSU.
// A granted command is registered and held on the ALSU inputs for the
// ALSU pipeline latency. The ALSU result is then sampled and returned
// on a one-cycle tagged response strobe.
module alsu_sequencer #(
    parameter int unsigned ALSU_LAT = 3
) (
    input  logic        CLK,
    input  logic        RST_n,

    input  logic        req0_valid,
    input  logic [15:0] req0_cmd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_cmd,
    output logic        req1_ready,

    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [5:0]  rsp_out,
    output logic        rsp_err,
    output logic [7:0]  err_cnt,
    output logic        busy,

    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_direction,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds
);

    localparam int unsigned CNT_W = (ALSU_LAT < 1) ? 1 : $clog2(ALSU_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALSU_LAT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             rr_ptr;     // requester granted last
    logic [15:0]      cmd_q;
    logic             id_q;

    logic             arb_open;
    logic             gnt_any;
    logic             grant;
    logic             hs;
    logic [15:0]      gnt_cmd;

    // Grant selection: a lone valid wins; on a tie the requester not granted last wins
    always_comb begin
        grant   = 1'b0;
        gnt_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~rr_ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // RESP arbitrates exactly like IDLE, so a new command can start in the strobe cycle
    assign arb_open   = (state == IDLE) || (state == RESP);
    assign hs         = arb_open && gnt_any;
    assign gnt_cmd    = grant ? req1_cmd : req0_cmd;
    assign req0_ready = arb_open && req0_valid && (grant == 1'b0);
    assign req1_ready = arb_open && req1_valid && (grant == 1'b1);
    assign busy       = (state != IDLE);

    // ALSU inputs come straight from the command register so they cannot glitch
    assign alsu_A         = cmd_q[15:13];
    assign alsu_B         = cmd_q[12:10];
    assign alsu_opcode    = cmd_q[9:7];
    assign alsu_cin       = cmd_q[6];
    assign alsu_serial_in = cmd_q[5];
    assign alsu_direction = cmd_q[4];
    assign alsu_red_op_A  = cmd_q[3];
    assign alsu_red_op_B  = cmd_q[2];
    assign alsu_bypass_A  = cmd_q[1];
    assign alsu_bypass_B  = cmd_q[0];

    // Sequencer state and latency countdown
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        state    <= WAIT;
                        wait_cnt <= LAT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (hs) begin
                        state    <= WAIT;
                        wait_cnt <= LAT_INIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Command capture and round-robin pointer update on each handshake
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cmd_q  <= '0;
            id_q   <= 1'b0;
            rr_ptr <= 1'b1;
        end else if (hs) begin
            cmd_q  <= gnt_cmd;
            id_q   <= grant;
            rr_ptr <= grant;
        end
    end

    // Response sampling at the end of the last WAIT cycle; strobe and error flag last one cycle
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= '0;
            rsp_err   <= 1'b0;
        end else if ((state == WAIT) && (wait_cnt == '0)) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_out   <= alsu_out;
            rsp_err   <= alsu_leds[0];
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end
    end

    // Saturating error counter, updated at the end of the RESP cycle
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            err_cnt <= '0;
        end else if ((state == RESP) && rsp_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alsu_sequencer.sv
// tb_alsu_sequencer
// Directed bench for alsu_sequencer with a small behavioural ALSU
// (3-stage registered result) attached to the sequencer's ALSU ports.
module tb_alsu_sequencer;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_cmd, req1_cmd;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic [5:0]  rsp_out;
    logic [7:0]  err_cnt;
    logic [2:0]  alsu_A, alsu_B, alsu_opcode;
    logic        alsu_cin, alsu_serial_in, alsu_direction;
    logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic [15:0] alsu_bus;

    int n_tests = 0;
    int n_fail  = 0;

    alsu_sequencer #(.ALSU_LAT(3)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_err(rsp_err),
        .err_cnt(err_cnt), .busy(busy),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds)
    );

    always #5 CLK = ~CLK;

    assign alsu_bus = {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_direction,
                       alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B};

    // Behavioural ALSU: {err, out} computed from the inputs, delayed by three registers
    logic [6:0] alsu_f;
    logic [6:0] p1 = '0, p2 = '0, p3 = '0;

    always_comb begin
        alsu_f = '0;
        case (alsu_opcode)
            3'b000:  alsu_f = {1'b0, 3'b000, alsu_A & alsu_B};
            3'b001:  alsu_f = {1'b0, 3'b000, alsu_A ^ alsu_B};
            3'b010:  alsu_f = {1'b0, {3'b000, alsu_A} + {3'b000, alsu_B} + {5'b00000, alsu_cin}};
            3'b011:  alsu_f = {1'b0, {3'b000, alsu_A} * {3'b000, alsu_B}};
            3'b100,
            3'b101:  alsu_f = '0;
            default: alsu_f = {1'b1, 6'b000000};
        endcase
    end

    always @(posedge CLK) begin
        p1 <= alsu_f;
        p2 <= p1;
        p3 <= p2;
    end

    assign alsu_out  = p3[5:0];
    assign alsu_leds = {15'b0, p3[6]};

    localparam logic [15:0] CMD_AND = 16'hAC00; // A=101 B=011 op=000
    localparam logic [15:0] CMD_ADD = 16'hFD40; // A=111 B=111 op=010 cin=1
    localparam logic [15:0] CMD_INV = 16'h0300; // A=000 B=000 op=110

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One command from an idle sequencer; checks every cycle through the cycle after RESP
    task automatic send(input logic id, input logic [15:0] cmd, input logic [5:0] eo,
                        input logic eerr, input logic [7:0] ecnt);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_cmd = cmd;
        end else begin
            req1_valid = 1'b1; req1_cmd = cmd;
        end
        #1;
        check("ready_own",   id ? req1_ready : req0_ready, 16'd1);
        check("ready_other", id ? req0_ready : req1_ready, 16'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0; req0_cmd = '0; req1_cmd = '0;
        for (int c = 1; c <= 4; c++) begin
            check("wait_bus",   alsu_bus, cmd);
            check("wait_valid", rsp_valid, 16'd0);
            check("wait_busy",  busy, 16'd1);
            step();
        end
        check("resp_valid", rsp_valid, 16'd1);
        check("resp_id",    rsp_id, 16'(id));
        check("resp_out",   rsp_out, 16'(eo));
        check("resp_err",   rsp_err, 16'(eerr));
        check("resp_bus",   alsu_bus, cmd);
        step();
        check("post_valid", rsp_valid, 16'd0);
        check("post_err",   rsp_err, 16'd0);
        check("post_out",   rsp_out, 16'(eo));
        check("post_id",    rsp_id, 16'(id));
        check("post_cnt",   err_cnt, 16'(ecnt));
        check("post_busy",  busy, 16'd0);
        check("post_bus",   alsu_bus, cmd);
    endtask

    initial begin
        RST_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_cmd = '0; req1_cmd = '0;

        // Reset state, checked before any clock edge
        #2;
        check("rst_bus",    alsu_bus, 16'd0);
        check("rst_valid",  rsp_valid, 16'd0);
        check("rst_out",    rsp_out, 16'd0);
        check("rst_id",     rsp_id, 16'd0);
        check("rst_err",    rsp_err, 16'd0);
        check("rst_cnt",    err_cnt, 16'd0);
        check("rst_busy",   busy, 16'd0);
        step();
        step();
        RST_n = 1'b1;
        step();

        // Directed commands
        send(1'b0, CMD_AND, 6'b000001, 1'b0, 8'd0);
        send(1'b1, CMD_ADD, 6'b001111, 1'b0, 8'd0);
        send(1'b0, CMD_INV, 6'b000000, 1'b1, 8'd1);

        // Error counter saturation: 256 invalid commands in total
        for (int k = 2; k <= 256; k++) begin
            send(k[0], CMD_INV, 6'b000000, 1'b1, (k > 255) ? 8'd255 : 8'(k));
        end
        send(1'b1, CMD_ADD, 6'b001111, 1'b0, 8'd255);

        // Reset asserted in cycle 2 of a command
        req0_valid = 1'b1; req0_cmd = CMD_AND;
        step();
        req0_valid = 1'b0; req0_cmd = '0;
        step();
        RST_n = 1'b0;
        #1;
        check("mid_valid", rsp_valid, 16'd0);
        check("mid_out",   rsp_out, 16'd0);
        check("mid_id",    rsp_id, 16'd0);
        check("mid_cnt",   err_cnt, 16'd0);
        check("mid_busy",  busy, 16'd0);
        check("mid_bus",   alsu_bus, 16'd0);
        step();
        RST_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("mid_nostrobe", rsp_valid, 16'd0);
            step();
        end

        // Both requesters valid after reset: grants in cycles 0, 5, 10
        req0_valid = 1'b1; req0_cmd = CMD_AND;
        req1_valid = 1'b1; req1_cmd = CMD_ADD;
        #1;
        for (int c = 0; c <= 11; c++) begin
            check("tie_ready0", req0_ready, 16'((c == 0) || (c == 10)));
            check("tie_ready1", req1_ready, 16'(c == 5));
            check("tie_valid",  rsp_valid,  16'((c == 5) || (c == 10)));
            if (c == 5) begin
                check("tie_id5",  rsp_id, 16'd0);
                check("tie_out5", rsp_out, 16'd1);
            end
            if (c == 10) begin
                check("tie_id10",  rsp_id, 16'd1);
                check("tie_out10", rsp_out, 16'd15);
            end
            if (c >= 1 && c <= 5)  check("tie_bus0", alsu_bus, CMD_AND);
            if (c >= 6 && c <= 10) check("tie_bus1", alsu_bus, CMD_ADD);
            if (c == 11)           check("tie_bus2", alsu_bus, CMD_AND);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 6; c++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
